// File: rtl/pkt_width_up_conv_pkg.sv
// Shared definitions for the packet width up-converter.
//   state_t     : frame FSM states
//   mty_width   : width of the empty-byte count for a packed word
//   usedw_width : width of the FIFO occupancy count (0..depth inclusive)
package pkt_width_up_conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    PACK  = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int mty_width(input int ratio, input int in_w);
    return $clog2(ratio * in_w / 8 + 1);
  endfunction

  function automatic int usedw_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with a registered head.
//   wr_en/wr_data : push; ignored while full
//   full          : occupancy == DEPTH
//   rd_en         : pop the head when rd_vld (consumer ready)
//   rd_data       : registered copy of the head entry, stable until popped
//   rd_vld        : registered non-empty flag
//   usedw         : occupancy, head entry included
module sync_fifo
  import pkt_width_up_conv_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [WIDTH-1:0]              wr_data,
  output logic                          full,
  input  logic                          rd_en,
  output logic [WIDTH-1:0]              rd_data,
  output logic                          rd_vld,
  output logic [usedw_width(DEPTH)-1:0] usedw
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = usedw_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp, rp_nx;
  logic [CW-1:0]    cnt, remain;
  logic             wr_ok, rd_ok;

  assign full   = (cnt == CW'(DEPTH));
  assign wr_ok  = wr_en & ~full;
  assign rd_ok  = rd_en & (cnt != '0);
  assign rp_nx  = rp + AW'(rd_ok);
  assign remain = cnt - CW'(rd_ok);
  assign usedw  = cnt;

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wp] <= wr_data;
  end

  // The head register is loaded with whatever entry will sit at rp_nx after
  // this edge; when that slot is the one being written now, take wr_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp      <= '0;
      rp      <= '0;
      cnt     <= '0;
      rd_vld  <= 1'b0;
      rd_data <= '0;
    end else begin
      wp     <= wp + AW'(wr_ok);
      rp     <= rp_nx;
      cnt    <= remain + CW'(wr_ok);
      rd_vld <= (remain != '0) | wr_ok;
      if (remain != '0)
        rd_data <= mem[rp_nx];
      else if (wr_ok)
        rd_data <= wr_data;
    end
  end

endmodule

// File: rtl/pkt_width_up_conv.sv
// Packs RATIO input words of IN_W bits into one output word, first beat in the
// MSBs, for one armed frame at a time, and buffers packed words in a FIFO.
//   din/din_vld/din_sop/din_eop : input beats
//   frame_len/frame_arm         : frame word limit (0 = unlimited), arm pulse
//   dout/dout_vld/dout_rdy      : packed output, valid/ready
//   dout_sop/dout_eop/dout_mty  : frame markers and empty byte count
//   usedw                       : FIFO occupancy in output words
//   frame_done/err_ovf/err_proto: status pulses
module pkt_width_up_conv
  import pkt_width_up_conv_pkg::*;
#(
  parameter int IN_W       = 16,
  parameter int RATIO      = 3,
  parameter int FIFO_DEPTH = 512,
  parameter int LEN_W      = 19
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [IN_W-1:0]                     din,
  input  logic                                din_vld,
  input  logic                                din_sop,
  input  logic                                din_eop,
  input  logic [LEN_W-1:0]                    frame_len,
  input  logic                                frame_arm,
  output logic [IN_W*RATIO-1:0]               dout,
  output logic                                dout_vld,
  input  logic                                dout_rdy,
  output logic                                dout_sop,
  output logic                                dout_eop,
  output logic [mty_width(RATIO, IN_W)-1:0]   dout_mty,
  output logic [usedw_width(FIFO_DEPTH)-1:0]  usedw,
  output logic                                frame_done,
  output logic                                err_ovf,
  output logic                                err_proto
);

  localparam int OUT_W  = IN_W * RATIO;
  localparam int MTY_W  = mty_width(RATIO, IN_W);
  localparam int LANE_W = $clog2(RATIO);
  localparam int FW     = OUT_W + 2 + MTY_W;

  state_t            state, state_nx;
  logic [LEN_W-1:0]  len_q, wcnt_q, wcnt;
  logic [LANE_W-1:0] lane_q, lane;
  logic [OUT_W-1:0]  pack_q, word;
  logic [MTY_W-1:0]  mty;
  logic              first, accept, full_word, last_word, close;
  logic              stg_vld, fifo_full;
  logic [FW-1:0]     stg_data, fifo_q;

  // On the sop beat the lane, word count and partial word restart from zero,
  // so no explicit clear is needed between frames.
  always_comb begin
    state_nx  = state;
    first     = (state == ARMED);
    accept    = din_vld & ((first & din_sop) | (state == PACK));
    lane      = first ? '0 : lane_q;
    wcnt      = first ? '0 : wcnt_q;
    word      = first ? '0 : pack_q;
    for (int unsigned k = 0; k < RATIO; k++) begin
      if (lane == LANE_W'(k)) word[IN_W*(RATIO-k)-1 -: IN_W] = din;
    end
    full_word = (lane == LANE_W'(RATIO - 1));
    last_word = din_eop | (full_word & (len_q != '0) & (wcnt + 1'b1 == len_q));
    close     = accept & (full_word | din_eop);
    mty       = MTY_W'((RATIO - 1 - int'(lane)) * (IN_W / 8));
    case (state)
      IDLE, DONE: if (frame_arm) state_nx = ARMED;
      ARMED:      if (accept) state_nx = (close & last_word) ? DONE : PACK;
      PACK:       if (close & last_word) state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      len_q     <= '0;
      wcnt_q    <= '0;
      lane_q    <= '0;
      pack_q    <= '0;
      stg_vld   <= 1'b0;
      stg_data  <= '0;
      err_proto <= 1'b0;
    end else begin
      state <= state_nx;
      if (frame_arm && (state == IDLE || state == DONE)) len_q <= frame_len;
      if (accept) begin
        if (close) begin
          lane_q <= '0;
          wcnt_q <= wcnt + 1'b1;
          pack_q <= '0;
        end else begin
          lane_q <= lane + 1'b1;
          wcnt_q <= wcnt;
          pack_q <= word;
        end
      end
      stg_vld <= close;
      if (close) stg_data <= {word, (wcnt == '0), last_word, mty};
      err_proto <= din_vld & din_sop & (state == PACK);
    end
  end

  sync_fifo #(
    .WIDTH(FW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (stg_vld),
    .wr_data(stg_data),
    .full   (fifo_full),
    .rd_en  (dout_rdy),
    .rd_data(fifo_q),
    .rd_vld (dout_vld),
    .usedw  (usedw)
  );

  assign {dout, dout_sop, dout_eop, dout_mty} = fifo_q;

  assign frame_done = stg_vld & stg_data[MTY_W] & ~fifo_full;
  assign err_ovf    = stg_vld & fifo_full;

endmodule

// File: doc/pkt_width_up_conv.md
PKT_WIDTH_UP_CONV -- requirements
Module: pkt_width_up_conv

Interface
REQ-001 Parameter IN_W, default 16: input word width; SHALL be a multiple of 8.
REQ-002 Parameter RATIO, default 3: input words packed per output word; range 2..8.
REQ-003 Parameter FIFO_DEPTH, default 512: output FIFO depth in output words; power of 2.
REQ-004 Parameter LEN_W, default 19: width of frame_len.
REQ-005 Ports:
  clk  in  1  clock, all logic rising-edge.
  rst_n  in  1  asynchronous, active-low reset.
  din  in  IN_W  input data.
  din_vld  in  1  input word valid.
  din_sop  in  1  first word of packet, qualified by din_vld.
  din_eop  in  1  last word of packet, qualified by din_vld.
  frame_len  in  LEN_W  max output words per frame, sampled on arm.
  frame_arm  in  1  one-cycle pulse enabling capture of the next frame.
  dout  out  IN_W*RATIO  packed output word.
  dout_vld  out  1  output valid.
  dout_rdy  in  1  downstream ready.
  dout_sop  out  1  first output word of frame.
  dout_eop  out  1  last output word of frame.
  dout_mty  out  MTY_W  empty bytes in dout; MTY_W = clog2(RATIO*IN_W/8+1).
  usedw  out  clog2(FIFO_DEPTH)+1  FIFO occupancy, output words.
  frame_done  out  1  one-cycle pulse when last word of frame is written into the FIFO.
  err_ovf  out  1  one-cycle pulse when a packed word is dropped because the FIFO is full.
  err_proto  out  1  one-cycle pulse on protocol violation.

Function
REQ-006 FSM states: IDLE, ARMED, PACK, DONE.
REQ-007 IDLE/DONE -> ARMED on frame_arm. The frame_len value is latched on that arm cycle. A din_sop in the same cycle is ignored.
REQ-008 ARMED -> PACK on din_vld&din_sop. That beat is lane 0 of the first output word.
REQ-009 PACK -> DONE on din_vld&din_eop, or when the output-word count reaches the latched frame_len.
REQ-010 The latched frame_len = 0 SHALL be treated as unlimited.
REQ-011 Input beats in IDLE, ARMED (without sop) and DONE SHALL be discarded without error.
REQ-012 Lane k of an output word SHALL occupy bits [IN_W*(RATIO-k)-1 -: IN_W]: first beat in the MSBs. Unfilled lanes SHALL be zero.
REQ-013 A word closes when RATIO beats have been packed, or on eop/frame_len termination with a partial fill of f beats.
REQ-014 For a closed word, mty = (RATIO-f)*IN_W/8; a full word has mty = 0.
REQ-015 sop flag = first word of frame; eop flag = word closing the frame.
REQ-016 din_vld&din_sop while in PACK: the beat is packed as data, sop is ignored, and err_proto pulses.
REQ-017 frame_arm while in ARMED or PACK SHALL be ignored.
REQ-018 A closed word is written to the FIFO on the cycle after closing.
REQ-019 When a word is written: usedw increments, and frame_done pulses in that cycle if the word carries eop.
REQ-020 FIFO full at write time: the word is dropped and err_ovf pulses. The frame continues; a dropped eop word still moves the FSM to DONE.
REQ-021 Output uses valid/ready. dout*, dout_vld SHALL be registered. A word transfers when dout_vld&dout_rdy.
REQ-022 While dout_vld=1 and dout_rdy=0, all dout* SHALL hold stable.
REQ-023 Minimum latency from the closing input beat to dout_vld is 2 cycles, with FIFO empty and dout_rdy=1.
REQ-024 Sustained throughput SHALL be 1 output word per cycle.
REQ-025 Simultaneous FIFO write and read SHALL leave usedw unchanged.
REQ-026 Pointers wrap modulo FIFO_DEPTH.

Reset
REQ-027 On rst_n low, asynchronously: FSM=IDLE, FIFO empty, usedw=0.
REQ-028 On rst_n low, asynchronously, all of these SHALL be 0: dout, dout_vld, dout_sop, dout_eop, dout_mty, frame_done, err_ovf, err_proto.
REQ-029 Reset mid-frame SHALL discard the partial word and all FIFO contents. No eop is emitted.

Structure
REQ-030 The shared package SHALL hold the FSM state enum and the MTY_W/usedw width functions.
REQ-031 The FIFO SHALL be one sub-module, sync_fifo. It is single-clock, show-ahead, parameterised by width IN_W*RATIO+2+MTY_W and FIFO_DEPTH.
REQ-032 Target RTL size is 120-400 lines.

Verification
REQ-033 Defaults, arm, 7-beat frame 0x0001..0x0007 (sop on 1, eop on 7), dout_rdy=1 -> 3 words:
  - 0x000100020003 sop=1 mty=0
  - 0x000400050006 mty=0
  - 0x000700000000 eop=1 mty=4
  - frame_done pulses once.
REQ-034 Single beat with sop&eop, value 0xABCD -> one word 0xABCD00000000 with sop=1, eop=1, mty=4.
REQ-035 frame_len=2, 12-beat packet, no arm afterwards -> 2 words out, second with eop=1; the remaining 6 beats are discarded; a new sop is ignored until the next arm.
REQ-036 FIFO_DEPTH=4, dout_rdy=0, 18-beat frame -> usedw=4; err_ovf pulses twice; the last 2 words are lost.
REQ-037 dout_rdy toggling 1/0 each cycle during a 30-beat frame -> all 10 words delivered in order, outputs stable while stalled.
REQ-038 rst_n asserted after 4 beats of a frame -> all outputs 0 and usedw=0 immediately; after release, no output until arm plus new sop.
